vscale_hazard_unit: RTL
=======================

Name: vscale_hazard_unit

Overview:
- Parametrised hazard/bypass controller for the vscale pipeline. Tracks in-flight register writers over NUM_STAGES post-DX stages, each with its own result latency.
- Adds a scoreboard for one multi-cycle (long-latency) unit, such as mul/div.
- Produces per-operand bypass stage selects, the DX stall, and an abort signal for the long-latency unit.
- Generalises the fixed single-WB-stage bypass/load-use logic to arbitrary depth and latency.

Parameters:
- NUM_STAGES, 2, post-DX pipeline stages tracked (>=1).
- REG_ADDR_WIDTH, 5, register address width.
- NUM_REGS, 32, scoreboard entries (2**REG_ADDR_WIDTH).
- LAT_WIDTH, 2, width of res_lat; must hold NUM_STAGES.
- SEL_WIDTH, 2, bypass select width; equals clog2(NUM_STAGES+1).
- CNT_WIDTH, 32, hazard-stall performance counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- issue_valid  in  1  DX holds a live, unkilled instruction.
- rs1_addr  in  REG_ADDR_WIDTH  DX source 1.
- rs2_addr  in  REG_ADDR_WIDTH  DX source 2.
- uses_rs1  in  1  DX reads rs1.
- uses_rs2  in  1  DX reads rs2.
- rd_addr  in  REG_ADDR_WIDTH  DX destination.
- wr_reg  in  1  DX writes rd.
- res_lat  in  LAT_WIDTH  stage index (1..NUM_STAGES) at which the DX result becomes bypassable.
- long_lat  in  1  DX op goes to the multi-cycle unit.
- stall_in  in  1  downstream stall (dmem_wait); freezes the tracker.
- flush  in  1  exception/kill of all in-flight ops.
- ll_done  in  1  multi-cycle unit writes back this cycle.
- ll_rd  in  REG_ADDR_WIDTH  destination of ll_done.
- stall_DX  out  1  hold DX.
- bypass_rs1  out  SEL_WIDTH  0 = regfile, k = forward from stage k.
- bypass_rs2  out  SEL_WIDTH  as bypass_rs1.
- ll_issue  out  1  DX long-latency op accepted this cycle.
- ll_abort  out  1  kill the multi-cycle unit.
- hazard_cycles  out  CNT_WIDTH  saturating count of hazard stalls.

Behaviour:
- **Reset** (reset==0 at posedge):
  - All tracker entries invalid; busy[] = 0; ll_busy = 0; hazard_cycles = 0.
  - Consequently stall_DX = stall_in, bypass_* = 0, ll_issue = 0, ll_abort = 0.
  - Reset overrides flush and all other inputs.
- **Tracker**: entries e[1..NUM_STAGES] of {v, rd, lat}.
  - If !stall_in: e[k] <= e[k-1] for k >= 2, and e[1] <= {accept && wr_reg && rd_addr!=0 && !long_lat, rd_addr, res_lat}.
  - accept = issue_valid && !stall_DX. A hazard stall inserts a bubble (v = 0) into e[1].
  - If stall_in: all entries hold.
- **Operand check** (per source s, only when uses_s and addr_s != 0; otherwise sel = 0, no stall):
  - Find the smallest k with e[k].v and e[k].rd == addr_s (youngest match wins).
  - If found and k >= e[k].lat: sel = k, no stall. If found and k < e[k].lat: raw stall.
  - If not found and busy[addr_s]: raw stall. Otherwise sel = 0.
- **Long-latency unit**:
  - Structural stall if long_lat && ll_busy && !ll_done.
  - WAW stall if wr_reg && rd_addr != 0 && busy[rd_addr] && !(ll_done && ll_rd == rd_addr).
  - ll_issue = accept && long_lat && !stall_in. On ll_issue: ll_busy <= 1, and busy[rd_addr] <= 1 when rd_addr != 0.
  - On ll_done: busy[ll_rd] <= 0, ll_busy <= 0. A same-cycle ll_done and ll_issue leaves the set winning: ll_busy stays 1, and busy[rd] is set even if rd == ll_rd.
- **Stall and counter**:
  - hazard = issue_valid && (raw1 || raw2 || waw || structural).
  - stall_DX = hazard || stall_in.
  - hazard_cycles increments when hazard && !stall_in && !flush, and saturates at all-ones.
- **Flush**:
  - Clears all e[k].v, busy[], and ll_busy next cycle; hazard_cycles is kept.
  - ll_abort = flush && ll_busy, combinational.
  - A same-cycle ll_issue is suppressed by flush.
  - Flush has priority over stall_in.
- **Latency and legality**:
  - All outputs are combinational from current state plus DX inputs; state changes are visible the next cycle.
  - res_lat = 0 is treated as 1. res_lat > NUM_STAGES is illegal; the implementation carries an assertion for it.

Decomposition:
- Into vscale_ctrl_constants.vh:
  - HAZ_SEL_RF (0).
  - HAZ_LAT_ALU (1).
  - HAZ_LAT_MEM (NUM_STAGES default).
  - Width defines HAZ_SEL_WIDTH and HAZ_LAT_WIDTH.
- Sub-module vscale_hazard_src_check: the priority match over tracker entries plus the busy lookup for one operand. It is instantiated twice (rs1, rs2) and outputs {sel, raw_stall}.

Test Plan:
- ALU then dependent op: "add x5" (res_lat 1) issued, next cycle DX reads rs1 = x5 -> bypass_rs1 = 1, stall_DX = 0.
- Load-use: load x6 with res_lat 2, next cycle uses rs2 = x6 -> stall_DX = 1 for one cycle, then bypass_rs2 = 2; hazard_cycles = 1.
- Long-latency: div x7 issued (ll_issue = 1), dependent op stalls; ll_done with ll_rd = 7 in cycle t -> stall_DX = 0 in cycle t+1, bypass_rs1 = 0.
- Structural/WAW: second long_lat while ll_busy -> stall until ll_done. Same-cycle ll_done (x7) and ll_issue (x7) -> busy[7] = 1 and ll_busy = 1 afterwards.
- Flush with ll_busy = 1 and two valid entries -> ll_abort = 1 that cycle; next cycle all bypass_* = 0, stall_DX = 0 for a dependent op.
- stall_in = 1 for 3 cycles with entry at stage 1 -> entry holds, hazard_cycles unchanged. Reset (reset = 0) mid-stall -> all state cleared, counter = 0.

Source files
------------

// File: rtl/vscale_hazard_unit_pkg.sv
// Shared constants for the vscale hazard/bypass controller: bypass select
// encodings, canonical result latencies and default field widths.
package vscale_hazard_unit_pkg;

  localparam int HAZ_SEL_RF    = 0;
  localparam int HAZ_LAT_ALU   = 1;
  localparam int HAZ_LAT_MEM   = 2;
  localparam int HAZ_SEL_WIDTH = 2;
  localparam int HAZ_LAT_WIDTH = 2;

endpackage

// File: rtl/vscale_hazard_unit_if.sv
// DX-side bundle between the pipeline control and the hazard unit.
// The pipeline is the master; the hazard unit is the slave.
interface vscale_hazard_unit_if
  import vscale_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LAT_WIDTH      = HAZ_LAT_WIDTH,
  parameter int SEL_WIDTH      = HAZ_SEL_WIDTH,
  parameter int CNT_WIDTH      = 32
) ();

  logic                      issue_valid;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr;
  logic                      uses_rs1;
  logic                      uses_rs2;
  logic [REG_ADDR_WIDTH-1:0] rd_addr;
  logic                      wr_reg;
  logic [LAT_WIDTH-1:0]      res_lat;
  logic                      long_lat;
  logic                      stall_in;
  logic                      flush;
  logic                      ll_done;
  logic [REG_ADDR_WIDTH-1:0] ll_rd;

  logic                      stall_DX;
  logic [SEL_WIDTH-1:0]      bypass_rs1;
  logic [SEL_WIDTH-1:0]      bypass_rs2;
  logic                      ll_issue;
  logic                      ll_abort;
  logic [CNT_WIDTH-1:0]      hazard_cycles;

  modport master (
    output issue_valid, rs1_addr, rs2_addr, uses_rs1, uses_rs2, rd_addr, wr_reg,
           res_lat, long_lat, stall_in, flush, ll_done, ll_rd,
    input  stall_DX, bypass_rs1, bypass_rs2, ll_issue, ll_abort, hazard_cycles
  );

  modport slave (
    input  issue_valid, rs1_addr, rs2_addr, uses_rs1, uses_rs2, rd_addr, wr_reg,
           res_lat, long_lat, stall_in, flush, ll_done, ll_rd,
    output stall_DX, bypass_rs1, bypass_rs2, ll_issue, ll_abort, hazard_cycles
  );

endinterface

// File: rtl/vscale_hazard_unit_src_check.sv
// Per-operand dependency check: youngest matching in-flight writer picks the
// bypass stage, otherwise a pending long-latency write forces a RAW stall.
module vscale_hazard_src_check
  import vscale_hazard_unit_pkg::*;
#(
  parameter int NUM_STAGES     = 2,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_REGS       = 2 ** REG_ADDR_WIDTH,
  parameter int LAT_WIDTH      = HAZ_LAT_WIDTH,
  parameter int SEL_WIDTH      = HAZ_SEL_WIDTH
) (
  input  logic                                      uses_i,
  input  logic [REG_ADDR_WIDTH-1:0]                 addr_i,
  input  logic [NUM_STAGES-1:0]                     entV_i,
  input  logic [NUM_STAGES-1:0][REG_ADDR_WIDTH-1:0] entRd_i,
  input  logic [NUM_STAGES-1:0][LAT_WIDTH-1:0]      entLat_i,
  input  logic [NUM_REGS-1:0]                       busy_i,
  output logic [SEL_WIDTH-1:0]                      sel_o,
  output logic                                      rawStall_o
);

  logic found;

  // Scan from stage 1 upward so the youngest writer of the register wins.
  always_comb begin
    sel_o      = SEL_WIDTH'(HAZ_SEL_RF);
    rawStall_o = 1'b0;
    found      = 1'b0;
    if (uses_i && addr_i != '0) begin
      for (int k = 1; k <= NUM_STAGES; k++) begin
        if (!found && entV_i[k-1] && entRd_i[k-1] == addr_i) begin
          found = 1'b1;
          if (k >= int'(entLat_i[k-1])) sel_o = SEL_WIDTH'(k);
          else rawStall_o = 1'b1;
        end
      end
      if (!found && busy_i[addr_i]) rawStall_o = 1'b1;
    end
  end

endmodule

// File: rtl/vscale_hazard_unit.sv
// Hazard/bypass controller: tracks in-flight writers over NUM_STAGES stages
// and scoreboards a single multi-cycle unit.
module vscale_hazard_unit
  import vscale_hazard_unit_pkg::*;
#(
  parameter int NUM_STAGES     = 2,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_REGS       = 2 ** REG_ADDR_WIDTH,
  parameter int LAT_WIDTH      = HAZ_LAT_WIDTH,
  parameter int SEL_WIDTH      = HAZ_SEL_WIDTH,
  parameter int CNT_WIDTH      = 32
) (
  input logic               clk,
  input logic               reset,
  vscale_hazard_unit_if.slave hz
);

  logic [NUM_STAGES-1:0]                     entV_q, entV_d;
  logic [NUM_STAGES-1:0][REG_ADDR_WIDTH-1:0] entRd_q, entRd_d;
  logic [NUM_STAGES-1:0][LAT_WIDTH-1:0]      entLat_q, entLat_d;
  logic [NUM_REGS-1:0]                       busy_q, busy_d;
  logic                                      llBusy_q, llBusy_d;
  logic [CNT_WIDTH-1:0]                      hazCnt_q, hazCnt_d;

  logic raw1, raw2, waw, structural, hazard, stallDx, accept, llIssue;

  vscale_hazard_src_check #(
    .NUM_STAGES(NUM_STAGES), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .NUM_REGS(NUM_REGS),
    .LAT_WIDTH(LAT_WIDTH), .SEL_WIDTH(SEL_WIDTH)
  ) u_rs1_check (
    .uses_i(hz.uses_rs1), .addr_i(hz.rs1_addr), .entV_i(entV_q), .entRd_i(entRd_q),
    .entLat_i(entLat_q), .busy_i(busy_q), .sel_o(hz.bypass_rs1), .rawStall_o(raw1)
  );

  vscale_hazard_src_check #(
    .NUM_STAGES(NUM_STAGES), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .NUM_REGS(NUM_REGS),
    .LAT_WIDTH(LAT_WIDTH), .SEL_WIDTH(SEL_WIDTH)
  ) u_rs2_check (
    .uses_i(hz.uses_rs2), .addr_i(hz.rs2_addr), .entV_i(entV_q), .entRd_i(entRd_q),
    .entLat_i(entLat_q), .busy_i(busy_q), .sel_o(hz.bypass_rs2), .rawStall_o(raw2)
  );

  // A retiring long-latency write frees its unit and its destination this cycle.
  assign structural = hz.long_lat && llBusy_q && !hz.ll_done;
  assign waw        = hz.wr_reg && hz.rd_addr != '0 && busy_q[hz.rd_addr]
                      && !(hz.ll_done && hz.ll_rd == hz.rd_addr);
  assign hazard     = hz.issue_valid && (raw1 || raw2 || waw || structural);
  assign stallDx    = hazard || hz.stall_in;
  assign accept     = hz.issue_valid && !stallDx;
  assign llIssue    = accept && hz.long_lat && !hz.stall_in && !hz.flush;

  assign hz.stall_DX      = stallDx;
  assign hz.ll_issue      = llIssue;
  assign hz.ll_abort      = hz.flush && llBusy_q;
  assign hz.hazard_cycles = hazCnt_q;

  always_comb begin
    entV_d   = entV_q;
    entRd_d  = entRd_q;
    entLat_d = entLat_q;
    busy_d   = busy_q;
    llBusy_d = llBusy_q;
    hazCnt_d = hazCnt_q;
    if (hz.flush) begin
      entV_d   = '0;
      busy_d   = '0;
      llBusy_d = 1'b0;
    end else begin
      if (!hz.stall_in) begin
        for (int k = NUM_STAGES - 1; k >= 1; k--) begin
          entV_d[k]   = entV_q[k-1];
          entRd_d[k]  = entRd_q[k-1];
          entLat_d[k] = entLat_q[k-1];
        end
        entV_d[0]   = accept && hz.wr_reg && hz.rd_addr != '0 && !hz.long_lat;
        entRd_d[0]  = hz.rd_addr;
        entLat_d[0] = (hz.res_lat == '0) ? LAT_WIDTH'(HAZ_LAT_ALU) : hz.res_lat;
      end
      // Issue is applied after completion so a same-cycle set wins.
      if (hz.ll_done) begin
        busy_d[hz.ll_rd] = 1'b0;
        llBusy_d         = 1'b0;
      end
      if (llIssue) begin
        llBusy_d = 1'b1;
        if (hz.rd_addr != '0) busy_d[hz.rd_addr] = 1'b1;
      end
      if (hazard && !hz.stall_in && hazCnt_q != '1) hazCnt_d = hazCnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      entV_q   <= '0;
      entRd_q  <= '0;
      entLat_q <= '0;
      busy_q   <= '0;
      llBusy_q <= 1'b0;
      hazCnt_q <= '0;
    end else begin
      entV_q   <= entV_d;
      entRd_q  <= entRd_d;
      entLat_q <= entLat_d;
      busy_q   <= busy_d;
      llBusy_q <= llBusy_d;
      hazCnt_q <= hazCnt_d;
    end
  end

  resLatLegal: assert property (@(posedge clk) disable iff (!reset)
    (hz.issue_valid && hz.wr_reg && !hz.long_lat) |-> (int'(hz.res_lat) <= NUM_STAGES));

endmodule
